// File: rtl/multiply_unsigned_pkg.sv
// Shared constants for the ALU mul/div unit: FSM encodings and default operand width.
package multiply_unsigned_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multiply_unsigned_step.sv
// One shift-add iteration: conditional add of the multiplicand into the upper
// accumulator half, then a logical right shift of the whole accumulator.
module multiply_step
  import multiply_unsigned_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] acc_added;

  // acc[2W] is always 0 entering a step (cleared by the previous shift), so the
  // WIDTH+1-bit sum holds the carry without loss.
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    acc_added = acc;
    if (acc[0]) begin
      acc_added[2*WIDTH:WIDTH] = upper_sum;
    end
    acc_next = {1'b0, acc_added[2*WIDTH:1]};
  end

endmodule

// File: rtl/multiply_unsigned.sv
// Sequential unsigned shift-add multiplier with start/ready handshake; WIDTH
// iterations per product, one per clock.
module multiply_unsigned
  import multiply_unsigned_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   out,
  output logic                 overflow,
  output logic                 busy,
  output logic                 ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH:0]   acc_step;

  multiply_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .acc_next (acc_step)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{(WIDTH+1){1'b0}}, b};
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = acc_step;
        count_d = count_q + CW'(1);
        // Result is captured on the final step so out/overflow are ready with DONE.
        if (count_q == CW'(WIDTH-1)) begin
          state_d = ST_DONE;
          out_d   = acc_step[2*WIDTH-1:0];
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out      = out_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_RUN);
  assign ready    = (state_q == ST_DONE);

endmodule

// File: tb/tb_multiply_unsigned.sv
// Self-checking bench for multiply_unsigned: directed scenarios plus randomized
// operands compared against a plain-arithmetic product model.
module tb_multiply_unsigned;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] out;
  logic           overflow, busy, ready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multiply_unsigned #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .out      (out),
    .overflow (overflow),
    .busy     (busy),
    .ready    (ready)
  );

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts clock edges after the accepting edge until ready is seen (bounded).
  task automatic wait_ready(output int cycles, output bit busy_ok);
    cycles = 0;
    busy_ok = 1'b1;
    while (!ready && cycles <= 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({out, overflow, busy, ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: out=%h ovf=%b busy=%b ready=%b, want all 0", out, overflow, busy, ready);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out, overflow, busy, ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: out=%h ovf=%b busy=%b ready=%b, want all 0", out, overflow, busy, ready);
    end
  endtask

  task automatic test_basic;
    int c; bit ok;
    launch(32'd3, 32'd5);
    wait_ready(c, ok);
    $display("op a=3 b=5 out=%h ovf=%b cycles=%0d", out, overflow, c);
    vectors++;
    if (c !== 32 || !ok) begin
      miscompares++;
      $display("FAIL basic_latency: cycles=%0d busy_ok=%b, want 32 and 1", c, ok);
    end
    vectors++;
    if (out !== 64'h0000_0000_0000_000F || overflow !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: out=%h ovf=%b busy=%b, want 000000000000000f 0 0", out, overflow, busy);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || out !== 64'h0000_0000_0000_000F) begin
      miscompares++;
      $display("FAIL basic_hold: ready=%b out=%h, want 1 000000000000000f", ready, out);
    end
  endtask

  task automatic test_carry;
    int c; bit ok;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready(c, ok);
    $display("op a=ffffffff b=ffffffff out=%h ovf=%b cycles=%0d", out, overflow, c);
    vectors++;
    if (c !== 32 || out !== 64'hFFFF_FFFE_0000_0001 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL carry: cycles=%0d out=%h ovf=%b, want 32 fffffffe00000001 1", c, out, overflow);
    end
  endtask

  task automatic test_zero_and_high;
    int c; bit ok;
    launch(32'h0000_0000, 32'h1234_5678);
    wait_ready(c, ok);
    $display("op a=00000000 b=12345678 out=%h ovf=%b cycles=%0d", out, overflow, c);
    vectors++;
    if (c !== 32 || !ok || out !== '0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_operand: cycles=%0d out=%h ovf=%b, want 32 0 0", c, out, overflow);
    end
    launch(32'h0001_0000, 32'h0001_0000);
    wait_ready(c, ok);
    $display("op a=00010000 b=00010000 out=%h ovf=%b cycles=%0d", out, overflow, c);
    vectors++;
    if (c !== 32 || out !== 64'h0000_0001_0000_0000 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL high_word: cycles=%0d out=%h ovf=%b, want 32 0000000100000000 1", c, out, overflow);
    end
  endtask

  task automatic test_start_ignored;
    int c; bit ok;
    launch(32'd7, 32'd6);
    repeat (10) @(negedge clk);
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(c, ok);
    c = c + 11;
    $display("op a=7 b=6 (restart ignored) out=%h cycles=%0d", out, c);
    vectors++;
    if (c !== 32 || !ok || out !== 64'd42) begin
      miscompares++;
      $display("FAIL start_in_run: cycles=%0d busy_ok=%b out=%0d, want 32 1 42", c, ok, out);
    end
  endtask

  task automatic test_back_to_back;
    int last, events, c;
    bit ok;
    last = -1; events = 0;
    @(negedge clk);
    a = 32'd2; b = 32'd9; start = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 100; t++) begin
      if (ready === 1'b1) begin
        events++;
        $display("op a=2 b=9 (held start) out=%0d t=%0d", out, t);
        vectors++;
        if ((last < 0 && t !== 32) || (last >= 0 && t - last !== 33) || out !== 64'd18 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL back_to_back: t=%0d last=%0d out=%0d ovf=%b, want period 33 (first at 32) out=18", t, last, out, overflow);
        end
        last = t;
      end
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (events !== 3) begin
      miscompares++;
      $display("FAIL back_to_back_count: ready pulses=%0d, want 3", events);
    end
    wait_ready(c, ok);
  endtask

  task automatic test_reset_mid_run;
    int c; bit ok;
    launch(32'd100, 32'd100);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({out, overflow, busy, ready} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: out=%h ovf=%b busy=%b ready=%b, want all 0", out, overflow, busy, ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b ready=%b, want 0 0", busy, ready);
    end
    launch(32'd100, 32'd100);
    wait_ready(c, ok);
    $display("op a=100 b=100 out=%0d cycles=%0d", out, c);
    vectors++;
    if (c !== 32 || out !== 64'd10000 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: cycles=%0d out=%0d ovf=%b, want 32 10000 0", c, out, overflow);
    end
  endtask

  task automatic test_random;
    logic [W-1:0]   av, bv;
    logic [2*W-1:0] exp_p;
    logic           exp_o;
    int c;
    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 3))
        0: begin av = $urandom; bv = $urandom; end
        1: begin av = 32'hFFFF_FFFF - $urandom_range(0, 3); bv = $urandom; end
        2: begin av = $urandom; bv = 32'h0000_0000; end
        default: begin av = $urandom_range(0, 255); bv = $urandom_range(0, 65535); end
      endcase
      exp_p = 64'(av) * 64'(bv);
      exp_o = (exp_p >> W) != 0;
      launch(av, bv);
      c = 0;
      // Scramble operand inputs while iterating; the captured values must win.
      while (!ready && c <= 200) begin
        a = $urandom; b = $urandom;
        @(negedge clk);
        c++;
      end
      $display("op a=%h b=%h out=%h ovf=%b cycles=%0d", av, bv, out, overflow, c);
      vectors++;
      if (c !== 32 || out !== exp_p || overflow !== exp_o || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL random: a=%h b=%h cycles=%0d out=%h ovf=%b busy=%b, want 32 %h %b 0", av, bv, c, out, overflow, busy, exp_p, exp_o);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_zero_and_high;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
